lfsr_word_gen: RTL

- Parametrised Fibonacci LFSR pseudo-random source for the karaoke audio path: dither, noise and effect randomisation.
- Provides a serial random bit every enabled cycle, as the existing 4-bit generator does.
- Adds configurable width and feedback polynomial, zero-seed lock-up protection, and an on-demand word mode. In word mode, OUT_BITS consecutive bits are packed into a sample word with a request/valid handshake.

---
 rtl/lfsr_word_gen_if.sv | 26 ++
 rtl/lfsr_word_gen.sv | 98 +++++++++
 2 files changed

// File: rtl/lfsr_word_gen_if.sv
// Control and data bundle for lfsr_word_gen: seed/step controls, serial tap,
// and the word-mode request/valid handshake.
interface lfsr_word_gen_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned OUT_BITS = 8
);
    logic [WIDTH-1:0]    seed;
    logic                load;
    logic                en;
    logic                word_req;
    logic                q;
    logic [WIDTH-1:0]    state;
    logic [OUT_BITS-1:0] word;
    logic                word_valid;
    logic                busy;

    modport master (
        output seed, load, en, word_req,
        input  q, state, word, word_valid, busy
    );

    modport slave (
        input  seed, load, en, word_req,
        output q, state, word, word_valid, busy
    );
endinterface

// File: rtl/lfsr_word_gen.sv
// Fibonacci LFSR random source: serial bit every enabled cycle, plus an on-demand
// word mode that packs OUT_BITS consecutive serial bits MSB-first.
module lfsr_word_gen #(
    parameter int unsigned       WIDTH     = 16,
    parameter logic [WIDTH-1:0]  TAPS      = 16'hD008,
    parameter int unsigned       OUT_BITS  = 8,
    parameter logic [WIDTH-1:0]  SEED_INIT = {WIDTH{1'b1}}
) (
    input  logic          clk,
    input  logic          rst,
    lfsr_word_gen_if.slave bus
);

    localparam int unsigned CntW = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(OUT_BITS - 1);

    typedef enum logic [0:0] {StIdle, StShift} fsm_e;

    fsm_e                fsm_q, fsm_d;
    logic [WIDTH-1:0]    state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [OUT_BITS-1:0] shreg_q, shreg_d;
    logic [OUT_BITS-1:0] word_q, word_d;
    logic                valid_q, valid_d;

    logic                fb;
    logic [WIDTH-1:0]    step;
    logic [OUT_BITS-1:0] shifted;

    assign fb   = ^(state_q & TAPS);
    assign step = {state_q[WIDTH-2:0], fb};
    // Truncating cast keeps this valid for OUT_BITS == 1.
    assign shifted = OUT_BITS'({shreg_q, state_q[WIDTH-1]});

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        word_d  = word_q;
        valid_d = 1'b0;

        if (bus.load) begin
            // A zero seed would lock the register; force the LSB instead.
            state_d = (bus.seed == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : bus.seed;
            fsm_d   = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (fsm_q)
                StIdle: begin
                    if (bus.word_req) begin
                        fsm_d = StShift;
                        cnt_d = '0;
                    end else if (bus.en) begin
                        state_d = step;
                    end
                end
                StShift: begin
                    shreg_d = shifted;
                    state_d = step;
                    cnt_d   = cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        word_d  = shifted;
                        valid_d = 1'b1;
                        fsm_d   = StIdle;
                        cnt_d   = '0;
                    end
                end
                default: fsm_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= StIdle;
            state_q <= SEED_INIT;
            cnt_q   <= '0;
            shreg_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign bus.q          = state_q[WIDTH-1];
    assign bus.state      = state_q;
    assign bus.word       = word_q;
    assign bus.word_valid = valid_q;
    assign bus.busy       = (fsm_q == StShift);

endmodule
